// File: rtl/score_keeper_if.sv
// Match-control bus between the match driver (start, ball position) and score_keeper
// (scores, serve hold, match status).
interface score_keeper_if;
  logic       start;
  logic [9:0] ball_x_location;
  logic [3:0] P1_score;
  logic [3:0] P2_score;
  logic       serve_hold;
  logic       game_active;
  logic       game_over;
  logic [1:0] winner;

  modport master (
    output start, ball_x_location,
    input  P1_score, P2_score, serve_hold, game_active, game_over, winner
  );

  modport slave (
    input  start, ball_x_location,
    output P1_score, P2_score, serve_hold, game_active, game_over, winner
  );
endinterface

// File: rtl/score_keeper.sv
// Pong match control: edge-detected goal scoring, serve hold and game-over sequencing.
// Optional SCORE_WIN_BY_TWO_EN: a win also needs a 2-point lead (15 always ends the match).
module score_keeper #(
  parameter int H_ACTIVE    = 640,
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_DELAY = 50000000,
  parameter int DLY_W       = 26
) (
  input  logic          clk,
  input  logic          reset,
  score_keeper_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PLAY     = 2'd1,
    SCORED   = 2'd2,
    GAMEOVER = 2'd3
  } state_t;

  localparam logic [9:0]       H_C      = 10'(H_ACTIVE);
  localparam logic [3:0]       WIN_C    = 4'(WIN_SCORE);
  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(SERVE_DELAY - 1);
  localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);
  localparam logic [DLY_W-1:0] DLY_ZERO = DLY_W'(0);

  state_t           state_r;
  logic [DLY_W-1:0] dly_cnt_r;
  logic             start_q_r;
  logic             goal_q_r;
  logic [3:0]       p1_score_r;
  logic [3:0]       p2_score_r;
  logic [1:0]       winner_r;
  logic             serve_hold_r;
  logic             game_active_r;
  logic             game_over_r;

  logic       goal_left_s;
  logic       goal_right_s;
  logic       goal_s;
  logic       start_rise_s;
  logic       goal_rise_s;
  logic [3:0] p1_inc_s;
  logic [3:0] p2_inc_s;
  logic       p1_wins_s;
  logic       p2_wins_s;

  // Output flags {serve_hold, game_active, game_over} for the state being entered.
  function automatic logic [2:0] outs_f(input state_t st);
    case (st)
      IDLE:     outs_f = 3'b100;
      PLAY:     outs_f = 3'b010;
      SCORED:   outs_f = 3'b100;
      GAMEOVER: outs_f = 3'b101;
      default:  outs_f = 3'b100;
    endcase
  endfunction

  assign goal_left_s  = (bus.ball_x_location == 10'd0);
  assign goal_right_s = (bus.ball_x_location >= H_C);
  assign goal_s       = goal_left_s | goal_right_s;
  assign start_rise_s = bus.start & ~start_q_r;
  assign goal_rise_s  = goal_s & ~goal_q_r;
  assign p1_inc_s     = p1_score_r + 4'd1;
  assign p2_inc_s     = p2_score_r + 4'd1;

`ifdef SCORE_WIN_BY_TWO_EN
  function automatic logic win_by_two_f(input logic [3:0] new_score, input logic [3:0] opp_score);
    win_by_two_f = ((new_score >= WIN_C) && ({1'b0, new_score} >= ({1'b0, opp_score} + 5'd2)))
                   || (new_score == 4'd15);
  endfunction

  assign p1_wins_s = win_by_two_f(p1_inc_s, p2_score_r);
  assign p2_wins_s = win_by_two_f(p2_inc_s, p1_score_r);
`else
  assign p1_wins_s = (p1_inc_s == WIN_C);
  assign p2_wins_s = (p2_inc_s == WIN_C);
`endif

  // Match FSM with edge history, scores, serve-delay counter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      dly_cnt_r     <= DLY_ZERO;
      start_q_r     <= 1'b1;
      goal_q_r      <= 1'b0;
      p1_score_r    <= 4'd0;
      p2_score_r    <= 4'd0;
      winner_r      <= 2'b00;
      serve_hold_r  <= 1'b1;
      game_active_r <= 1'b0;
      game_over_r   <= 1'b0;
    end else begin
      start_q_r <= bus.start;
      goal_q_r  <= goal_s;
      case (state_r)
        IDLE, GAMEOVER: begin
          if (start_rise_s) begin
            p1_score_r <= 4'd0;
            p2_score_r <= 4'd0;
            winner_r   <= 2'b00;
            state_r    <= PLAY;
            {serve_hold_r, game_active_r, game_over_r} <= outs_f(PLAY);
          end
        end
        PLAY: begin
          if (goal_rise_s) begin
            if (goal_left_s) begin
              p2_score_r <= p2_inc_s;
              if (p2_wins_s) begin
                winner_r <= 2'b10;
                state_r  <= GAMEOVER;
                {serve_hold_r, game_active_r, game_over_r} <= outs_f(GAMEOVER);
              end else begin
                dly_cnt_r <= DLY_LOAD;
                state_r   <= SCORED;
                {serve_hold_r, game_active_r, game_over_r} <= outs_f(SCORED);
              end
            end else begin
              p1_score_r <= p1_inc_s;
              if (p1_wins_s) begin
                winner_r <= 2'b01;
                state_r  <= GAMEOVER;
                {serve_hold_r, game_active_r, game_over_r} <= outs_f(GAMEOVER);
              end else begin
                dly_cnt_r <= DLY_LOAD;
                state_r   <= SCORED;
                {serve_hold_r, game_active_r, game_over_r} <= outs_f(SCORED);
              end
            end
          end
        end
        SCORED: begin
          // Counter runs SERVE_DELAY-1 down to 0, so the hold lasts SERVE_DELAY cycles.
          if (dly_cnt_r == DLY_ZERO) begin
            state_r <= PLAY;
            {serve_hold_r, game_active_r, game_over_r} <= outs_f(PLAY);
          end else begin
            dly_cnt_r <= dly_cnt_r - DLY_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          {serve_hold_r, game_active_r, game_over_r} <= outs_f(IDLE);
        end
      endcase
    end
  end

  assign bus.P1_score    = p1_score_r;
  assign bus.P2_score    = p2_score_r;
  assign bus.winner      = winner_r;
  assign bus.serve_hold  = serve_hold_r;
  assign bus.game_active = game_active_r;
  assign bus.game_over   = game_over_r;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed match scenarios plus a randomized run
// against a timestamp-based match model.
module tb_score_keeper;
  localparam int H_ACTIVE    = 640;
  localparam int WIN_SCORE   = 3;
  localparam int SERVE_DELAY = 4;
  localparam int DLY_W       = 3;

  localparam int PH_IDLE = 0;
  localparam int PH_PLAY = 1;
  localparam int PH_HOLD = 2;
  localparam int PH_OVER = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  score_keeper_if bus();

  score_keeper #(
    .H_ACTIVE(H_ACTIVE), .WIN_SCORE(WIN_SCORE),
    .SERVE_DELAY(SERVE_DELAY), .DLY_W(DLY_W)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Match model: scores as integers, serve hold tracked as the cycle number play resumes.
  int m_p1, m_p2, m_winner, m_phase, m_resume, m_cyc;
  bit m_prev_start, m_prev_goal;

  function automatic bit m_wins(input int mine, input int theirs);
`ifdef SCORE_WIN_BY_TWO_EN
    return ((mine >= WIN_SCORE) && (mine - theirs >= 2)) || (mine == 15);
`else
    return mine == WIN_SCORE;
`endif
  endfunction

  task automatic model_reset();
    m_p1 = 0; m_p2 = 0; m_winner = 0; m_phase = PH_IDLE;
    m_resume = 0; m_cyc = 0; m_prev_start = 1'b1; m_prev_goal = 1'b0;
  endtask

  task automatic model_edge(input bit s, input int bx);
    bit g, s_rise, g_rise;
    g = (bx == 0) || (bx >= H_ACTIVE);
    s_rise = s && !m_prev_start;
    g_rise = g && !m_prev_goal;
    m_cyc++;
    if (m_phase == PH_IDLE || m_phase == PH_OVER) begin
      if (s_rise) begin
        m_p1 = 0; m_p2 = 0; m_winner = 0; m_phase = PH_PLAY;
      end
    end else if (m_phase == PH_HOLD) begin
      if (m_cyc == m_resume) m_phase = PH_PLAY;
    end else if (g_rise) begin
      if (bx == 0) begin
        m_p2++;
        if (m_wins(m_p2, m_p1)) begin m_phase = PH_OVER; m_winner = 2; end
        else begin m_phase = PH_HOLD; m_resume = m_cyc + SERVE_DELAY; end
      end else begin
        m_p1++;
        if (m_wins(m_p1, m_p2)) begin m_phase = PH_OVER; m_winner = 1; end
        else begin m_phase = PH_HOLD; m_resume = m_cyc + SERVE_DELAY; end
      end
    end
    m_prev_start = s;
    m_prev_goal = g;
  endtask

  task automatic step(input bit s, input logic [9:0] bx);
    bus.start = s;
    bus.ball_x_location = bx;
    @(posedge clk);
    model_edge(s, int'(bx));
    #1;
  endtask

  // Goal at bx, then (optionally) idle the ball mid-screen until play resumes, bounded.
  task automatic score_goal(input logic [9:0] bx, input bit wait_play, output bit ok);
    int waited;
    step(1'b0, bx);
    waited = 0;
    while (wait_play && !bus.game_active && waited < 20) begin
      step(1'b0, 10'd320);
      waited++;
    end
    ok = !wait_play || bus.game_active;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.start = 1'b1;
    bus.ball_x_location = 10'd320;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.serve_hold, bus.game_active, bus.game_over} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required %b", {bus.serve_hold, bus.game_active, bus.game_over}, 3'b100);
    end
    n_cmp++;
    if ({bus.P1_score, bus.P2_score, bus.winner} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_scores: got %h required 000", {bus.P1_score, bus.P2_score, bus.winner});
    end
    reset = 1'b1;
    repeat (3) step(1'b1, 10'd320);
    n_cmp++;
    if ({bus.serve_hold, bus.game_active} !== 2'b10) begin
      n_fail++;
      $display("FAIL start_held_idle: got %b required 10", {bus.serve_hold, bus.game_active});
    end
    step(1'b0, 10'd320);
    step(1'b1, 10'd320);
    n_cmp++;
    if ({bus.serve_hold, bus.game_active, bus.P1_score, bus.P2_score} !== {2'b01, 8'h00}) begin
      n_fail++;
      $display("FAIL start_pulse: got %h required %h", {bus.serve_hold, bus.game_active, bus.P1_score, bus.P2_score}, {2'b01, 8'h00});
    end
  endtask

  task automatic test_goal_hold();
    int hold_cnt;
    step(1'b0, 10'd100);
    step(1'b0, 10'd100);
    step(1'b0, 10'd0);
    n_cmp++;
    if ({bus.P1_score, bus.P2_score, bus.serve_hold} !== {4'd0, 4'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL left_goal: got p1=%0d p2=%0d hold=%b required p1=0 p2=1 hold=1", bus.P1_score, bus.P2_score, bus.serve_hold);
    end
    hold_cnt = 1;
    repeat (9) begin
      step(1'b0, 10'd0);
      if (bus.serve_hold) hold_cnt++;
    end
    n_cmp++;
    if (hold_cnt != SERVE_DELAY) begin
      n_fail++;
      $display("FAIL hold_len: got %0d required %0d", hold_cnt, SERVE_DELAY);
    end
    n_cmp++;
    if ({bus.P2_score, bus.game_active} !== {4'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL parked_no_rescore: got p2=%0d active=%b required p2=1 active=1", bus.P2_score, bus.game_active);
    end
    step(1'b0, 10'd320);
  endtask

  task automatic test_p1_win();
    bit ok;
    for (int i = 1; i <= 3; i++) begin
      score_goal(10'd640, (i < 3), ok);
      n_cmp++;
      if (bus.P1_score !== 4'(i) || !ok) begin
        n_fail++;
        $display("FAIL p1_goal_%0d: got p1=%0d resumed=%b required p1=%0d resumed=1", i, bus.P1_score, ok, i);
      end
    end
    n_cmp++;
    if ({bus.game_over, bus.game_active, bus.winner} !== 4'b1001) begin
      n_fail++;
      $display("FAIL p1_win: got %b required 1001", {bus.game_over, bus.game_active, bus.winner});
    end
    step(1'b0, 10'd0);
    step(1'b0, 10'd640);
    step(1'b0, 10'd320);
    n_cmp++;
    if ({bus.P1_score, bus.P2_score, bus.winner, bus.game_over} !== {4'd3, 4'd1, 2'b01, 1'b1}) begin
      n_fail++;
      $display("FAIL gameover_frozen: got p1=%0d p2=%0d w=%b over=%b required 3 1 01 1", bus.P1_score, bus.P2_score, bus.winner, bus.game_over);
    end
  endtask

  task automatic test_restart();
    step(1'b1, 10'd320);
    n_cmp++;
    if ({bus.P1_score, bus.P2_score, bus.winner, bus.game_active, bus.game_over} !== {10'd0, 2'b10}) begin
      n_fail++;
      $display("FAIL restart: got p1=%0d p2=%0d w=%b act=%b over=%b required 0 0 00 1 0", bus.P1_score, bus.P2_score, bus.winner, bus.game_active, bus.game_over);
    end
    step(1'b0, 10'd320);
  endtask

  task automatic test_scored_ignore_and_async_reset();
    step(1'b0, 10'd0);
    step(1'b0, 10'd318);
    step(1'b1, 10'd0);
    step(1'b0, 10'd318);
    n_cmp++;
    if ({bus.P1_score, bus.P2_score, bus.serve_hold} !== {4'd0, 4'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL scored_ignores_goal: got p1=%0d p2=%0d hold=%b required 0 1 1", bus.P1_score, bus.P2_score, bus.serve_hold);
    end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({bus.P1_score, bus.P2_score, bus.winner, bus.serve_hold, bus.game_active, bus.game_over} !== {10'd0, 3'b100}) begin
      n_fail++;
      $display("FAIL async_reset: got %h required %h", {bus.P1_score, bus.P2_score, bus.winner, bus.serve_hold, bus.game_active, bus.game_over}, {10'd0, 3'b100});
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

`ifdef SCORE_WIN_BY_TWO_EN
  task automatic test_win_by_two();
    bit ok;
    bit all_ok;
    logic [9:0] seq [5];
    seq = '{10'd640, 10'd0, 10'd640, 10'd0, 10'd640};
    step(1'b0, 10'd320);
    step(1'b1, 10'd320);
    all_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      score_goal(seq[i], 1'b1, ok);
      all_ok = all_ok & ok;
    end
    n_cmp++;
    if ({bus.P1_score, bus.P2_score, bus.game_over} !== {4'd3, 4'd2, 1'b0} || !all_ok) begin
      n_fail++;
      $display("FAIL deuce_no_win: got p1=%0d p2=%0d over=%b resumed=%b required 3 2 0 1", bus.P1_score, bus.P2_score, bus.game_over, all_ok);
    end
    step(1'b0, 10'd640);
    n_cmp++;
    if ({bus.P1_score, bus.game_over, bus.winner} !== {4'd4, 1'b1, 2'b01}) begin
      n_fail++;
      $display("FAIL lead_two_win: got p1=%0d over=%b w=%b required 4 1 01", bus.P1_score, bus.game_over, bus.winner);
    end
  endtask
`endif

  task automatic test_random();
    logic [14:0] got, exp;
    bit s;
    int r;
    logic [9:0] bx;
    step(1'b0, 10'd320);
    step(1'b1, 10'd320);
    for (int i = 0; i < 800; i++) begin
      s = ($urandom_range(0, 24) == 0);
      r = $urandom_range(0, 3);
      if (r == 0) bx = 10'd0;
      else if (r == 1) bx = 10'($urandom_range(640, 1023));
      else bx = 10'($urandom_range(1, 639));
      step(s, bx);
      got = {bus.P1_score, bus.P2_score, bus.winner, bus.serve_hold, bus.game_active, bus.game_over};
      exp = {4'(m_p1), 4'(m_p2), 2'(m_winner), (m_phase != PH_PLAY), (m_phase == PH_PLAY), (m_phase == PH_OVER)};
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL random_cycle_%0d: got %h required %h", i, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_goal_hold();
    test_p1_win();
    test_restart();
    test_scored_ignore_and_async_reset();
`ifdef SCORE_WIN_BY_TWO_EN
    test_win_by_two();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
